sdram_req_arbiter: RTL and testbench



---
 rtl/sdram_req_arbiter_if.sv | 49 ++++
 rtl/sdram_req_arbiter.sv | 110 +++++++++++
 tb/tb_sdram_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_arbiter_if.sv
// Requester/controller signal bundle for the two-port SDRAM request arbiter.
// The arbiter takes the slave view; the requesters and controller side take the master view.
interface sdram_req_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          c_valid;
  logic          c_ready;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_rd_valid;
  logic [DW-1:0] c_rd_data;

  logic          grant;
  logic          err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  c_ready, c_rd_valid, c_rd_data,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output c_valid, c_we, c_addr, c_wdata,
    output grant, err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output c_ready, c_rd_valid, c_rd_data,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  c_valid, c_we, c_addr, c_wdata,
    input  grant, err
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter for two requesters onto one SDRAM controller port, one transaction at a time.
// Write ack 2 cycles after req (plus c_ready stall); read ack 1 cycle after c_rd_valid or forced by watchdog.
module sdram_req_arbiter #(
  parameter int AW         = 23,
  parameter int DW         = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  sdram_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  localparam logic [7:0]    WDOG_LAST    = 8'(RD_TIMEOUT - 1);
  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);

  state_t        state, state_nxt;
  logic          c_we_q;
  logic [AW-1:0] c_addr_q;
  logic [DW-1:0] c_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          grant_q;
  logic          last_grant_q;
  logic          err_q;
  logic [7:0]    wdog_q;

  logic          load_cmd;
  logic          win;
  logic          rd_hit;
  logic          rd_timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_cmd   = 1'b0;
    win        = 1'b0;
    rd_hit     = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          load_cmd  = 1'b1;
          // On a tie the requester that did not win last time goes next
          if (bus.m0_req && bus.m1_req) win = ~last_grant_q;
          else                          win = bus.m1_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.c_ready) state_nxt = c_we_q ? DONE : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.c_rd_valid) begin
          rd_hit    = 1'b1;
          state_nxt = DONE;
        end else if (wdog_q == WDOG_LAST) begin
          rd_timeout = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      c_we_q       <= 1'b0;
      c_addr_q     <= '0;
      c_wdata_q    <= '0;
      rdata_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      if (load_cmd) begin
        c_we_q       <= win ? bus.m1_we    : bus.m0_we;
        c_addr_q     <= win ? bus.m1_addr  : bus.m0_addr;
        c_wdata_q    <= win ? bus.m1_wdata : bus.m0_wdata;
        grant_q      <= win;
        last_grant_q <= win;
      end
      // Watchdog counts WAIT_RD cycles; it restarts on every command issue
      if (state == ISSUE)        wdog_q <= '0;
      else if (state == WAIT_RD) wdog_q <= wdog_q + 8'd1;
      if (rd_hit) begin
        rdata_q <= bus.c_rd_data;
      end else if (rd_timeout) begin
        rdata_q <= TIMEOUT_DATA;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.c_valid  = (state == ISSUE);
  assign bus.c_we     = c_we_q;
  assign bus.c_addr   = c_addr_q;
  assign bus.c_wdata  = c_wdata_q;
  assign bus.m0_ack   = (state == DONE) && !grant_q;
  assign bus.m1_ack   = (state == DONE) &&  grant_q;
  assign bus.m0_rdata = grant_q ? '0 : rdata_q;
  assign bus.m1_rdata = grant_q ? rdata_q : '0;
  assign bus.grant    = grant_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: expected acks queued at request time, popped at ack.
module tb_sdram_req_arbiter;
  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int TMO = 8;

  typedef struct {
    logic          who;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  sdram_req_arbiter_if #(.AW(AW), .DW(DW)) bus();

  sdram_req_arbiter #(.AW(AW), .DW(DW), .RD_TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic who, input logic [DW-1:0] rdata);
    exp_t e;
    e.who   = who;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_cvalid(input int bound, output int n);
    n = 0;
    while (bus.c_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("cvalid_seen", 64'(bus.c_valid), 64'd1);
  endtask

  task automatic respond(input int delay, input logic [DW-1:0] d);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("no_early_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    end
    bus.c_rd_valid = 1'b1;
    bus.c_rd_data  = d;
    tick();
    bus.c_rd_valid = 1'b0;
    bus.c_rd_data  = '0;
  endtask

  task automatic wait_ack(input string tag, input int bound, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (bus.m0_ack !== 1'b1 && bus.m1_ack !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ackbits"}, 64'({bus.m1_ack, bus.m0_ack}), e.who ? 64'd2 : 64'd1);
      chk({tag, "_rdata"}, 64'(e.who ? bus.m1_rdata : bus.m0_rdata), 64'(e.rdata));
      chk({tag, "_other_rdata"}, 64'(e.who ? bus.m0_rdata : bus.m1_rdata), 64'd0);
    end
  endtask

  initial begin
    int   n;
    logic w;

    rst            = 1'b1;
    bus.m0_req     = 1'b0;
    bus.m0_we      = 1'b0;
    bus.m0_addr    = '0;
    bus.m0_wdata   = '0;
    bus.m1_req     = 1'b0;
    bus.m1_we      = 1'b0;
    bus.m1_addr    = '0;
    bus.m1_wdata   = '0;
    bus.c_ready    = 1'b0;
    bus.c_rd_valid = 1'b0;
    bus.c_rd_data  = '0;
    repeat (2) tick();

    chk("rst_cvalid", 64'(bus.c_valid), 64'd0);
    chk("rst_cwe", 64'(bus.c_we), 64'd0);
    chk("rst_caddr", 64'(bus.c_addr), 64'd0);
    chk("rst_cwdata", 64'(bus.c_wdata), 64'd0);
    chk("rst_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    chk("rst_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    tick();

    // Single write from requester 0
    bus.c_ready  = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 23'h000100;
    bus.m0_wdata = 32'h0000003E;
    bus.m0_req   = 1'b1;
    push_exp(1'b0, 32'h0);
    tick();
    chk("t1_cvalid", 64'(bus.c_valid), 64'd1);
    chk("t1_cwe", 64'(bus.c_we), 64'd1);
    chk("t1_caddr", 64'(bus.c_addr), 64'h100);
    chk("t1_cwdata", 64'(bus.c_wdata), 64'h3E);
    chk("t1_grant", 64'(bus.grant), 64'd0);
    chk("t1_no_ack_c1", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    tick();
    wait_ack("t1", 5, 0);
    bus.m0_req = 1'b0;
    tick();
    chk("t1_idle", 64'({bus.c_valid, bus.m1_ack, bus.m0_ack}), 64'd0);

    // Single read from requester 1, data three cycles after handshake
    bus.m1_we   = 1'b0;
    bus.m1_addr = 23'h000200;
    bus.m1_req  = 1'b1;
    push_exp(1'b1, 32'h00000044);
    tick();
    chk("t2_cvalid", 64'(bus.c_valid), 64'd1);
    chk("t2_cwe", 64'(bus.c_we), 64'd0);
    chk("t2_caddr", 64'(bus.c_addr), 64'h200);
    chk("t2_grant", 64'(bus.grant), 64'd1);
    respond(3, 32'h00000044);
    wait_ack("t2", 5, 0);
    bus.m1_req = 1'b0;
    tick();

    // Write with c_ready low for five cycles; requester fields change meanwhile
    bus.c_ready  = 1'b0;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 23'h000300;
    bus.m0_wdata = 32'h00000055;
    bus.m0_req   = 1'b1;
    push_exp(1'b0, 32'h00000044);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_cvalid", 64'(bus.c_valid), 64'd1);
      chk("t4_caddr", 64'(bus.c_addr), 64'h300);
      chk("t4_cwdata", 64'(bus.c_wdata), 64'h55);
      chk("t4_cwe", 64'(bus.c_we), 64'd1);
      chk("t4_no_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
      if (i == 1) begin
        bus.m0_addr  = 23'h0003FF;
        bus.m0_wdata = 32'h000000FF;
        bus.m0_we    = 1'b0;
      end
      tick();
    end
    bus.c_ready = 1'b1;
    chk("t4_hs_caddr", 64'(bus.c_addr), 64'h300);
    chk("t4_hs_cvalid", 64'(bus.c_valid), 64'd1);
    tick();
    wait_ack("t4", 3, 0);
    bus.m0_req = 1'b0;
    tick();

    // Read with no response: watchdog forces completion
    bus.m1_we   = 1'b0;
    bus.m1_addr = 23'h000400;
    bus.m1_req  = 1'b1;
    push_exp(1'b1, 32'hDEADBEEF);
    tick();
    chk("t5_cvalid", 64'(bus.c_valid), 64'd1);
    chk("t5_err_before", 64'(bus.err), 64'd0);
    wait_ack("t5", 20, TMO + 1);
    chk("t5_err", 64'(bus.err), 64'd1);
    bus.m1_req = 1'b0;
    tick();
    bus.c_rd_valid = 1'b1;
    bus.c_rd_data  = 32'h00000077;
    tick();
    bus.c_rd_valid = 1'b0;
    bus.c_rd_data  = '0;
    chk("t5_stray_state", 64'({bus.c_valid, bus.m1_ack, bus.m0_ack}), 64'd0);
    chk("t5_stray_rdata", 64'(bus.m1_rdata), 64'hDEADBEEF);
    tick();
    chk("t5_stray_idle", 64'({bus.c_valid, bus.m1_ack, bus.m0_ack}), 64'd0);
    bus.m0_we   = 1'b0;
    bus.m0_addr = 23'h000500;
    bus.m0_req  = 1'b1;
    push_exp(1'b0, 32'h00000099);
    tick();
    chk("t5b_grant", 64'(bus.grant), 64'd0);
    respond(1, 32'h00000099);
    wait_ack("t5b", 5, 0);
    chk("t5b_err_sticky", 64'(bus.err), 64'd1);
    bus.m0_req = 1'b0;
    tick();

    // Reset while waiting for read data
    bus.m1_we   = 1'b0;
    bus.m1_addr = 23'h000600;
    bus.m1_req  = 1'b1;
    tick();
    chk("t6_issue", 64'(bus.c_valid), 64'd1);
    tick();
    chk("t6_waitrd", 64'({bus.c_valid, bus.grant}), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_cvalid", 64'(bus.c_valid), 64'd0);
    chk("t6_caddr", 64'(bus.c_addr), 64'd0);
    chk("t6_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    chk("t6_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'd0);
    chk("t6_grant", 64'(bus.grant), 64'd0);
    chk("t6_err", 64'(bus.err), 64'd0);
    bus.m1_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    bus.c_rd_valid = 1'b1;
    bus.c_rd_data  = 32'h00000012;
    tick();
    bus.c_rd_valid = 1'b0;
    bus.c_rd_data  = '0;
    chk("t6_late_resp", 64'({bus.c_valid, bus.m1_ack, bus.m0_ack, bus.err}), 64'd0);
    tick();

    // Both requesting reads continuously: grants alternate starting at 0
    bus.m0_we   = 1'b0;
    bus.m0_addr = 23'h000010;
    bus.m1_we   = 1'b0;
    bus.m1_addr = 23'h000020;
    bus.m0_req  = 1'b1;
    bus.m1_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = ((k % 2) == 1);
      wait_cvalid(10, n);
      if (k > 0) chk("t3_spacing", 64'(n), 64'd2);
      chk("t3_grant", 64'(bus.grant), 64'(w));
      chk("t3_caddr", 64'(bus.c_addr), w ? 64'h20 : 64'h10);
      push_exp(w, 32'hA000_0000 | 32'(k));
      respond(2, 32'hA000_0000 | 32'(k));
      wait_ack("t3", 5, 0);
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
